// File: rtl/fp_round_pack.sv
// Rounds an extended-precision product (sign/exp/frac + G,R,S) to bfloat16 with a
// selectable rounding mode, handling specials and overflow, behind a 2-stage valid/ready pipe.
module fp_round_pack #(
  parameter int EXP_WIDTH = 8,
  parameter int FRAC_BITS = 7,
  parameter int EXT_BITS  = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [EXP_WIDTH+FRAC_BITS+EXT_BITS:0] in_z,
  input  logic [2:0]                            in_rnd,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [EXP_WIDTH+FRAC_BITS:0]          out_z,
  output logic [7:0]                            out_status
);
  localparam int IN_W  = EXP_WIDTH + FRAC_BITS + EXT_BITS + 1;
  localparam int OUT_W = EXP_WIDTH + FRAC_BITS + 1;
  localparam logic [EXP_WIDTH-1:0] EXP_ALL1  = '1;
  localparam logic [EXP_WIDTH-1:0] EXP_MAXF  = EXP_ALL1 - 1'b1;
  localparam logic [FRAC_BITS-1:0] FRAC_ALL1 = '1;
  localparam int ST_ZERO = 0, ST_INF = 1, ST_INVALID = 2, ST_TINY = 3, ST_HUGE = 4, ST_INEXACT = 5;

  generate
    if (EXP_WIDTH != 8 || FRAC_BITS != 7 || EXT_BITS != 3) begin : g_param_check
      $fatal(1, "fp_round_pack supports only the bfloat16 geometry (8/7/3)");
    end
  endgenerate

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

  logic                 in_sign, in_g, in_r, in_s, in_grs, in_mant_nz;
  logic                 in_inc, in_ovf, in_inexact;
  logic [EXP_WIDTH-1:0] in_exp;
  logic [FRAC_BITS-1:0] in_frac;
  logic [2:0]           in_mode;
  cls_e                 in_cls;

  assign in_sign    = in_z[IN_W-1];
  assign in_exp     = in_z[IN_W-2 -: EXP_WIDTH];
  assign in_frac    = in_z[EXT_BITS +: FRAC_BITS];
  assign in_g       = in_z[EXT_BITS-1];
  assign in_r       = in_z[EXT_BITS-2];
  assign in_s       = |in_z[EXT_BITS-3:0];
  assign in_grs     = in_g | in_r | in_s;
  assign in_mant_nz = |in_z[FRAC_BITS+EXT_BITS-1:0];
  assign in_mode    = (in_rnd > 3'd4) ? 3'd0 : in_rnd;

  always_comb begin
    in_inc = 1'b0;
    case (in_mode)
      3'd0:    in_inc = in_g & (in_r | in_s | in_frac[0]);
      3'd2:    in_inc = ~in_sign & in_grs;
      3'd3:    in_inc = in_sign & in_grs;
      3'd4:    in_inc = in_g;
      default: in_inc = 1'b0;
    endcase
  end

  // Overflow is judged on the round-to-nearest magnitude, so the truncating
  // directions still report huge and clamp to max finite.
  assign in_ovf = (in_exp == EXP_MAXF) && (in_frac == FRAC_ALL1) && (in_inc || in_g);

  always_comb begin
    in_cls     = CLS_NORM;
    in_inexact = in_grs;
    if (in_exp == '0) begin
      in_cls     = CLS_ZERO;
      in_inexact = in_mant_nz;
    end else if (in_exp == EXP_ALL1) begin
      in_cls     = in_mant_nz ? CLS_NAN : CLS_INF;
      in_inexact = 1'b0;
    end
  end

  logic                 rdy_q, s2_ready, s1_load, s2_load;
  logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic                 s1_sign_q, s1_sign_d, s1_inc_q, s1_inc_d;
  logic                 s1_ovf_q, s1_ovf_d, s1_inexact_q, s1_inexact_d;
  logic [EXP_WIDTH-1:0] s1_exp_q, s1_exp_d;
  logic [FRAC_BITS-1:0] s1_frac_q, s1_frac_d;
  logic [2:0]           s1_mode_q, s1_mode_d;
  cls_e                 s1_cls_q, s1_cls_d;
  logic [OUT_W-1:0]     out_z_q, out_z_d, pk_z;
  logic [7:0]           out_status_q, out_status_d, pk_status;
  logic [FRAC_BITS:0]   frac_sum;
  logic                 to_inf;

  assign s2_ready = ~s2_valid_q | out_ready;
  assign in_ready = rdy_q & (~s1_valid_q | s2_ready);
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid_q & s2_ready;

  always_comb begin
    s1_valid_d   = in_ready ? in_valid : s1_valid_q;
    s1_sign_d    = s1_load ? in_sign    : s1_sign_q;
    s1_exp_d     = s1_load ? in_exp     : s1_exp_q;
    s1_frac_d    = s1_load ? in_frac    : s1_frac_q;
    s1_inc_d     = s1_load ? in_inc     : s1_inc_q;
    s1_ovf_d     = s1_load ? in_ovf     : s1_ovf_q;
    s1_inexact_d = s1_load ? in_inexact : s1_inexact_q;
    s1_mode_d    = s1_load ? in_mode    : s1_mode_q;
    s1_cls_d     = s1_load ? in_cls     : s1_cls_q;
  end

  always_comb begin
    frac_sum  = {1'b0, s1_frac_q} + {{FRAC_BITS{1'b0}}, s1_inc_q};
    to_inf    = (s1_mode_q == 3'd0) | (s1_mode_q == 3'd4) |
                ((s1_mode_q == 3'd2) & ~s1_sign_q) | ((s1_mode_q == 3'd3) & s1_sign_q);
    pk_z      = '0;
    pk_status = '0;
    case (s1_cls_q)
      CLS_ZERO: begin
        pk_z                  = {s1_sign_q, {(EXP_WIDTH+FRAC_BITS){1'b0}}};
        pk_status[ST_ZERO]    = 1'b1;
        pk_status[ST_TINY]    = s1_inexact_q;
        pk_status[ST_INEXACT] = s1_inexact_q;
      end
      CLS_INF: begin
        pk_z              = {s1_sign_q, EXP_ALL1, {FRAC_BITS{1'b0}}};
        pk_status[ST_INF] = 1'b1;
      end
      CLS_NAN: begin
        pk_z                  = {1'b0, EXP_ALL1, 1'b1, {(FRAC_BITS-1){1'b0}}};
        pk_status[ST_INVALID] = 1'b1;
      end
      default: begin
        if (s1_ovf_q) begin
          pk_z                  = to_inf ? {s1_sign_q, EXP_ALL1, {FRAC_BITS{1'b0}}}
                                         : {s1_sign_q, EXP_MAXF, FRAC_ALL1};
          pk_status[ST_INF]     = to_inf;
          pk_status[ST_HUGE]    = 1'b1;
          pk_status[ST_INEXACT] = 1'b1;
        end else begin
          pk_z = {s1_sign_q, s1_exp_q + {{(EXP_WIDTH-1){1'b0}}, frac_sum[FRAC_BITS]},
                  frac_sum[FRAC_BITS-1:0]};
          pk_status[ST_INEXACT] = s1_inexact_q;
        end
      end
    endcase
  end

  always_comb begin
    s2_valid_d   = s2_ready ? s1_valid_q : s2_valid_q;
    out_z_d      = s2_load ? pk_z : out_z_q;
    out_status_d = s2_load ? pk_status : out_status_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_frac_q    <= '0;
      s1_inc_q     <= 1'b0;
      s1_ovf_q     <= 1'b0;
      s1_inexact_q <= 1'b0;
      s1_mode_q    <= '0;
      s1_cls_q     <= CLS_NORM;
      s2_valid_q   <= 1'b0;
      out_z_q      <= '0;
      out_status_q <= '0;
    end else begin
      rdy_q        <= 1'b1;
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_frac_q    <= s1_frac_d;
      s1_inc_q     <= s1_inc_d;
      s1_ovf_q     <= s1_ovf_d;
      s1_inexact_q <= s1_inexact_d;
      s1_mode_q    <= s1_mode_d;
      s1_cls_q     <= s1_cls_d;
      s2_valid_q   <= s2_valid_d;
      out_z_q      <= out_z_d;
      out_status_q <= out_status_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_z      = out_z_q;
  assign out_status = out_status_q;
endmodule

// File: doc/fp_round_pack.md
# fp_round_pack

Output rounding and packing stage for the PE floating-point multiplier. It consumes the extended-precision product (sign, 8-bit exponent, 7-bit fraction plus 3 guard/round/sticky bits) and rounds it to bfloat16 using a selectable rounding mode. It handles specials and overflow, produces an 8-bit status word, and drives the PE output through a 2-stage valid/ready pipeline.

## Interface
- `EXP_WIDTH`, default 8: exponent bits, fixed; any other value is a fatal elaboration error.
- `FRAC_BITS`, default 7: output fraction bits, fixed.
- `EXT_BITS`, default 3: extra low bits on the input (guard, round, sticky).
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `in_valid`, input, 1: input word is valid.
- `in_ready`, output, 1: stage accepts the input word this cycle.
- `in_z`, input, 19: product; [18] sign, [17:10] exponent, [9:3] fraction, [2] G, [1] R, [0] S.
- `in_rnd`, input, 3: rounding mode, captured with `in_z`.
- `out_valid`, output, 1: result is valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_z`, output, 16: bfloat16 result.
- `out_status`, output, 8: [0] zero, [1] inf, [2] invalid, [3] tiny, [4] huge, [5] inexact, [7:6] always 0.

## Operation
- A transfer occurs on either side when valid and ready are both high at the rising edge.
- **Stage 1:** registers the input and computes the class and the increment decision.
- **Stage 2:** applies the increment and packs the result.
- Rounding modes:
  - 0: RNE, inc = G & (R | S | L), where L = fraction bit [3].
  - 1: toward zero, inc = 0.
  - 2: toward +inf, inc = ~sign & (G | R | S).
  - 3: toward -inf, inc = sign & (G | R | S).
  - 4: nearest-away, inc = G.
  - 5–7: treated as RNE.
- Normal input (exponent 1–254):
  - Compute the 8-bit sum {0, frac} + inc.
  - On carry-out, the fraction becomes 0 and the exponent becomes exponent+1.
  - Inexact = G | R | S.
- Overflow (rounded exponent reaches 255): set huge and inexact. The result depends on mode:
  - Modes 0 and 4: ±inf (0x7F80 / 0xFF80), and inf is set.
  - Mode 1: ±max finite (0x7F7F / 0xFF7F).
  - Mode 2: positive gives +inf (inf set); negative gives 0xFF7F.
  - Mode 3: negative gives -inf (inf set); positive gives 0x7F7F.
- Exponent 0:
  - Flush to signed zero and set zero.
  - If the 10-bit mantissa field is nonzero, also set tiny and inexact.
- Exponent 255:
  - Mantissa 0: signed inf, inf set, no rounding.
  - Mantissa nonzero: canonical NaN 0x7FC0 (sign dropped), invalid set.
- Status is computed per word and travels with its word. There is no sticky accumulation across words.

## Timing
- Reset (async, while `rst_n` is low):
  - Both stage valids clear; `out_valid` = 0.
  - `out_z` = 0, `out_status` = 0.
  - `in_ready` = 1 from the first edge after `rst_n` rises.
- Latency: 2 cycles from input transfer to `out_valid`. Throughput: 1 word per cycle while `out_ready` = 1.
- Ready rules:
  - s2_ready = ~s2_valid | `out_ready`.
  - `in_ready` = ~s1_valid | s2_ready.
  - There is no combinational path from `in_valid` to `in_ready`.
- Stall: while `out_valid` = 1 and `out_ready` = 0, `out_z` and `out_status` hold stable. Stage 1 fills, then `in_ready` falls. At most 2 words are in flight.
- Simultaneous output transfer and stage-1 advance in the same cycle: no bubble and no word lost.
- Order is strictly preserved.
- Reset asserted mid-stream discards all in-flight words. There is no partial output.

## Test plan
- **Identity:** `in_z`=0x1FC00, rnd 0 → `out_z`=0x3F80 and status 0x00 after exactly 2 cycles.
- **RNE ties:**
  - 0x1FC0C → 0x3F82, status 0x20.
  - 0x1FC14 → 0x3F82, status 0x20.
  - 0x1FC14 with rnd 4 → 0x3F83.
- **Carry into exponent:** 0x1FFFC, rnd 0 → 0x4000, status 0x20.
- **Overflow:** 0x3FBFC:
  - rnd 0 → 0x7F80, status 0x32.
  - rnd 1 → 0x7F7F, status 0x30.
  - rnd 3 → 0x7F7F, status 0x30.
- **Specials:**
  - 0x3FC01 → 0x7FC0, status 0x04.
  - 0x7FC00 → 0xFF80, status 0x02.
  - 0x00005 → 0x0000, status 0x29.
  - 0x40000 → 0x8000, status 0x01.
- **Backpressure and reset:**
  - Stream 4 words with `out_ready` low for 5 cycles: exactly 2 are accepted, `in_ready` = 0 and `out_z` is stable during the stall.
  - On release, all 4 words emerge in order on consecutive cycles.
  - Then pulse `rst_n` low with `out_valid` = 1: `out_valid` drops without waiting for a clock edge, and no stale word appears afterwards.
